// File: rtl/asym_ram_sdp_wide_read_pipe.sv
// Simple-dual-port asymmetric RAM: narrow write port, wide (RATIO-lane) synchronous read port with read-valid.
// Define ASYM_RAM_OUT_REG_EN for an extra output register (read latency 2 instead of 1); collisions are read-before-write.
module asym_ram_sdp_wide_read_pipe #(
    parameter int WR_WIDTH  = 8,
    parameter int RATIO     = 4,
    parameter int RD_DEPTH  = 64,
    parameter int LANE_MSB0 = 0,
    localparam int RD_WIDTH = WR_WIDTH * RATIO,
    localparam int WR_DEPTH = RD_DEPTH * RATIO,
    localparam int WR_AW    = $clog2(WR_DEPTH),
    localparam int RD_AW    = $clog2(RD_DEPTH),
    localparam int LW       = $clog2(RATIO)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                write_enable,
    input  logic [WR_AW-1:0]    write_addr,
    input  logic [WR_WIDTH-1:0] write_data,
    input  logic                read_enable,
    input  logic [RD_AW-1:0]    read_addr,
    output logic [RD_WIDTH-1:0] read_data,
    output logic                read_valid
);

    logic [WR_WIDTH-1:0] r_mem [WR_DEPTH];
    logic [RD_WIDTH-1:0] w_rd_word;
    logic [RD_WIDTH-1:0] r_rd_dat;
    logic                r_rd_vld;

    // Storage is deliberately unreset; writes are blocked while rst is high.
    always_ff @(posedge clk) begin
        if (write_enable && !rst) begin
            r_mem[write_addr] <= write_data;
        end
    end

    // Lane k comes from narrow address {read_addr, k}; LANE_MSB0 flips lane placement in the wide word.
    for (genvar k = 0; k < RATIO; k++) begin : g_lane
        localparam int             POS  = (LANE_MSB0 != 0) ? (RATIO - 1 - k) : k;
        localparam logic [LW-1:0]  LANE = LW'(k);
        assign w_rd_word[POS*WR_WIDTH +: WR_WIDTH] = r_mem[{read_addr, LANE}];
    end

    // Sampling the array before the same-edge write lands gives read-before-write on collisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_dat <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= read_enable;
            if (read_enable) begin
                r_rd_dat <= w_rd_word;
            end
        end
    end

`ifdef ASYM_RAM_OUT_REG_EN
    logic [RD_WIDTH-1:0] r_out_dat;
    logic                r_out_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_dat <= '0;
            r_out_vld <= 1'b0;
        end else begin
            r_out_vld <= r_rd_vld;
            if (r_rd_vld) begin
                r_out_dat <= r_rd_dat;
            end
        end
    end

    assign read_data  = r_out_dat;
    assign read_valid = r_out_vld;
`else
    assign read_data  = r_rd_dat;
    assign read_valid = r_rd_vld;
`endif

endmodule

// File: tb/tb_asym_ram_sdp_wide_read_pipe.sv
// Scoreboard bench: default instance (8b x4, lane0 LSB) and a reversed-lane instance (4b x8, lane0 MSB).
module tb_asym_ram_sdp_wide_read_pipe;

`ifdef ASYM_RAM_OUT_REG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    typedef struct {
        int          cyc;
        int          addr;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_a, re_a, we_b, re_b;
    logic [7:0]  wa_a, wd_a;
    logic [5:0]  ra_a, wa_b;
    logic [3:0]  wd_b;
    logic [2:0]  ra_b;
    logic [31:0] rdata_a, rdata_b;
    logic        read_valid_a, read_valid_b;

    logic [7:0]  mem_a [256];
    logic [3:0]  mem_b [64];
    logic [31:0] got_a [64];
    logic [31:0] got_b [8];
    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] hold_a = '0, hold_b = '0;
    int          run_a = 0, run_b = 0, last_run_a = 0, last_run_b = 0;
    int          cyc = 0;
    logic        rst_seen = 1'b0;
    logic        done = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    asym_ram_sdp_wide_read_pipe #(
        .WR_WIDTH(8), .RATIO(4), .RD_DEPTH(64), .LANE_MSB0(0)
    ) u_dut_a (
        .clk(clk), .rst(rst),
        .write_enable(we_a), .write_addr(wa_a), .write_data(wd_a),
        .read_enable(re_a), .read_addr(ra_a),
        .read_data(rdata_a), .read_valid(read_valid_a)
    );

    asym_ram_sdp_wide_read_pipe #(
        .WR_WIDTH(4), .RATIO(8), .RD_DEPTH(8), .LANE_MSB0(1)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .write_enable(we_b), .write_addr(wa_b), .write_data(wd_b),
        .read_enable(re_b), .read_addr(ra_b),
        .read_data(rdata_b), .read_valid(read_valid_b)
    );

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endfunction

    // Reference: a wide word is just RATIO consecutive narrow words, lane 0 at the low (A) or high (B) end.
    function automatic logic [31:0] model_a(int ra);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[k*8 +: 8] = mem_a[ra*4 + k];
        return r;
    endfunction

    function automatic logic [31:0] model_b(int ra);
        logic [31:0] r;
        for (int k = 0; k < 8; k++) r[(7-k)*4 +: 4] = mem_b[ra*8 + k];
        return r;
    endfunction

    // Issue side: the read sees the model before this edge's write is applied.
    always @(posedge clk) begin
        cyc = cyc + 1;
        rst_seen = rst;
        if (rst) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (re_a) q_a.push_back('{cyc, int'(ra_a), model_a(int'(ra_a))});
            if (re_b) q_b.push_back('{cyc, int'(ra_b), model_b(int'(ra_b))});
            if (we_a) mem_a[wa_a] = wd_a;
            if (we_b) mem_b[wa_b] = wd_b;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0 && !done) begin
            if (rst_seen) begin
                chk("a_rst_valid", 32'(read_valid_a), 32'h0);
                chk("a_rst_data", rdata_a, 32'h0);
                hold_a = '0;
                run_a  = 0;
            end else if (read_valid_a) begin
                run_a++;
                if (q_a.size() == 0) begin
                    chk("a_unexpected_valid", 32'(read_valid_a), 32'h0);
                end else begin
                    e = q_a.pop_front();
                    chk("a_data", rdata_a, e.dat);
                    chk("a_latency", cyc, e.cyc + RD_LAT - 1);
                    got_a[e.addr] = rdata_a;
                    hold_a = e.dat;
                end
            end else begin
                if (run_a != 0) last_run_a = run_a;
                run_a = 0;
                chk("a_hold", rdata_a, hold_a);
                if (q_a.size() != 0 && q_a[0].cyc + RD_LAT - 1 < cyc) begin
                    chk("a_missing_valid", 32'(read_valid_a), 32'h1);
                    void'(q_a.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0 && !done) begin
            if (rst_seen) begin
                chk("b_rst_valid", 32'(read_valid_b), 32'h0);
                chk("b_rst_data", rdata_b, 32'h0);
                hold_b = '0;
                run_b  = 0;
            end else if (read_valid_b) begin
                run_b++;
                if (q_b.size() == 0) begin
                    chk("b_unexpected_valid", 32'(read_valid_b), 32'h0);
                end else begin
                    e = q_b.pop_front();
                    chk("b_data", rdata_b, e.dat);
                    chk("b_latency", cyc, e.cyc + RD_LAT - 1);
                    got_b[e.addr] = rdata_b;
                    hold_b = e.dat;
                end
            end else begin
                if (run_b != 0) last_run_b = run_b;
                run_b = 0;
                chk("b_hold", rdata_b, hold_b);
                if (q_b.size() != 0 && q_b[0].cyc + RD_LAT - 1 < cyc) begin
                    chk("b_missing_valid", 32'(read_valid_b), 32'h1);
                    void'(q_b.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("drain_timeout", 32'(q_a.size() + q_b.size()), 32'h0);
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with reads requested: none of them may produce read_valid.
        rst = 1'b1;
        we_a = 1'b0; wa_a = '0; wd_a = '0; re_a = 1'b1; ra_a = 6'd5;
        we_b = 1'b0; wa_b = '0; wd_b = '0; re_b = 1'b1; ra_b = 3'd2;
        repeat (3) tick();
        rst = 1'b0; re_a = 1'b0; re_b = 1'b0;
        tick();

        for (int i = 0; i < 256; i++) begin
            we_a = 1'b1; wa_a = 8'(i); wd_a = 8'(i);
            we_b = (i < 64); wa_b = 6'(i); wd_b = 4'(i);
            tick();
        end
        we_a = 1'b0; we_b = 1'b0;

        for (int i = 0; i < 64; i++) begin
            re_a = 1'b1; ra_a = 6'(i);
            re_b = (i < 8); ra_b = 3'(i);
            tick();
        end
        re_a = 1'b0; re_b = 1'b0;
        drain();
        chk("fill_addr1", got_a[1], 32'h07060504);
        chk("fill_addr63", got_a[63], 32'hFFFEFDFC);
        chk("fill_run_len_a", last_run_a, 64);
        chk("rev_addr0", got_b[0], 32'h01234567);
        chk("rev_addr1", got_b[1], 32'h89ABCDEF);
        chk("rev_run_len_b", last_run_b, 8);

        for (int i = 8; i < 12; i++) begin
            we_a = 1'b1; wa_a = 8'(i); wd_a = 8'hAA;
            tick();
        end
        we_a = 1'b1; wa_a = 8'd9; wd_a = 8'h55; re_a = 1'b1; ra_a = 6'd2;
        tick();
        we_a = 1'b0; re_a = 1'b0;
        drain();
        chk("collision_old", got_a[2], 32'hAAAAAAAA);
        re_a = 1'b1; ra_a = 6'd2;
        tick();
        re_a = 1'b0;
        drain();
        chk("collision_new", got_a[2], 32'hAAAA55AA);

        repeat (5) tick();
        chk("hold_data", rdata_a, 32'hAAAA55AA);
        chk("hold_valid", 32'(read_valid_a), 32'h0);

        // Read on the reset edge is discarded.
        re_a = 1'b1; ra_a = 6'd3; rst = 1'b1;
        tick();
        rst = 1'b0; re_a = 1'b0;
        repeat (4) tick();
        chk("midrst_data", rdata_a, 32'h0);
        chk("midrst_valid", 32'(read_valid_a), 32'h0);

        // In-flight read dropped by a reset on the following edge.
        re_a = 1'b1; ra_a = 6'd4;
        tick();
        re_a = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("inflight_drop_data", rdata_a, 32'h0);

        re_a = 1'b1; ra_a = 6'd3;
        tick();
        re_a = 1'b0;
        drain();
        chk("post_rst_read", got_a[3], 32'h0F0E0D0C);

        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 59) == 0);
            we_a = $urandom_range(0, 1) == 1; wa_a = 8'($urandom_range(0, 255)); wd_a = 8'($urandom);
            re_a = $urandom_range(0, 3) != 0; ra_a = 6'($urandom_range(0, 63));
            we_b = $urandom_range(0, 1) == 1; wa_b = 6'($urandom_range(0, 63)); wd_b = 4'($urandom);
            re_b = $urandom_range(0, 3) != 0; ra_b = 3'($urandom_range(0, 7));
            tick();
        end
        rst = 1'b0; we_a = 1'b0; re_a = 1'b0; we_b = 1'b0; re_b = 1'b0;
        drain();

        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
